// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit seven-segment scan driver.
// Holds the scan state encoding, the blanking constants and the
// active-high hex segment table (bit order g,f,e,d,c,b,a).
package seg7_pkg;

  typedef enum logic [1:0] {
    SHOW_L = 2'd0,
    GAP_L  = 2'd1,
    SHOW_H = 2'd2,
    GAP_H  = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;

  // Active-high patterns, index = nibble value 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_dec.sv
// Hex nibble to seven-segment decoder for a common-anode display.
// Ports:
//   nib  in  4  nibble to display (0..F)
//   seg  out 7  segments g..a, active-low
module seg7_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  import seg7_pkg::*;

  assign seg = ~SEG_HEX[nib];

endmodule

// File: rtl/seg7_scan.sv
// Two-digit multiplexed seven-segment driver. Snapshots {QH,QL} once per
// frame, scans low then high digit with an all-off gap after each, and
// stretches the one-cycle carry C into a decimal-point flash.
// Ports:
//   Clk  in  1  system clock
//   MR   in  1  asynchronous active-low reset
//   QH   in  4  high nibble
//   QL   in  4  low nibble
//   C    in  1  carry flag (one-cycle pulse)
//   seg  out 7  segments g..a, active-low, registered
//   dp   out 1  decimal point, active-low, registered
//   an   out 2  digit enables (an[0]=low), active-low, registered
//
// state  | meaning
// SHOW_L | low digit lit for SCAN_DIV cycles
// GAP_L  | all digits off for DEAD cycles
// SHOW_H | high digit lit (or blanked if zero) for SCAN_DIV cycles
// GAP_H  | all digits off for DEAD cycles; leaving it takes a new snapshot
module seg7_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEAD     = 4,
  parameter int DP_HOLD  = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic       Clk,
  input  logic       MR,
  input  logic [3:0] QH,
  input  logic [3:0] QL,
  input  logic       C,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an
);
  import seg7_pkg::*;

  localparam int PH_MAX = (SCAN_DIV > DEAD) ? SCAN_DIV : DEAD;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int HOLD_W = $clog2(DP_HOLD + 1);

  scan_state_t       state, state_n;
  logic [PH_W-1:0]   ph, ph_n;
  logic              ph_last;
  logic [3:0]        snap_h, snap_l, snap_h_n, snap_l_n;
  logic              c_q;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [1:0]        an_n;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [3:0]        dec_nib;
  logic [6:0]        dec_seg;

  seg7_dec u_dec (
    .nib (dec_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state  <= SHOW_L;
      ph     <= '0;
      snap_h <= '0;
      snap_l <= '0;
      c_q    <= 1'b0;
      hold   <= '0;
      an     <= AN_OFF;
      seg    <= SEG_BLANK;
      dp     <= 1'b1;
    end else begin
      state  <= state_n;
      ph     <= ph_n;
      snap_h <= snap_h_n;
      snap_l <= snap_l_n;
      c_q    <= C;
      hold   <= hold_n;
      an     <= an_n;
      seg    <= seg_n;
      dp     <= dp_n;
    end
  end

  always_comb begin
    state_n = state;
    ph_n    = ph + 1'b1;
    if (state == SHOW_L || state == SHOW_H)
      ph_last = (ph == PH_W'(SCAN_DIV - 1));
    else
      ph_last = (ph == PH_W'(DEAD - 1));
    if (ph_last) begin
      ph_n = '0;
      case (state)
        SHOW_L:  state_n = GAP_L;
        GAP_L:   state_n = SHOW_H;
        SHOW_H:  state_n = GAP_H;
        default: state_n = SHOW_L;
      endcase
    end

    // Snapshot is taken on the edge that re-enters SHOW_L, so both digits
    // of one frame always come from the same counter value.
    snap_h_n = snap_h;
    snap_l_n = snap_l;
    if (state == GAP_H && ph_last) begin
      snap_h_n = QH;
      snap_l_n = QL;
    end

    // Only a rising edge of C (re)loads the stretch timer.
    hold_n = hold;
    if (C && !c_q)
      hold_n = HOLD_W'(DP_HOLD);
    else if (hold != '0)
      hold_n = hold - 1'b1;
  end

  // Outputs are decoded from next-state values so the registered outputs
  // change on the same edge as the state.
  always_comb begin
    an_n    = AN_OFF;
    dec_nib = snap_l_n;
    case (state_n)
      SHOW_L: an_n = 2'b10;
      SHOW_H: begin
        dec_nib = snap_h_n;
        if (!(BLANK_LZ != 0 && snap_h_n == 4'd0))
          an_n = 2'b01;
      end
      default: an_n = AN_OFF;
    endcase
    seg_n = (an_n == AN_OFF) ? SEG_BLANK : dec_seg;
    dp_n  = !((an_n != AN_OFF) && (hold_n != '0));
  end

endmodule
